fir_decimator: RTL and testbench

//   Downstream stage of the FIR filter. Takes one filtered WIDTH-bit sample per in_valid,

---
 rtl/fir_pkg.sv | 11 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/fir_decimator.sv | 109 ++++++++++
 tb/tb_fir_decimator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR-chain definitions: sample width, default decimator sizing and the
// sample type used by the FIR, the decimator and the output formatter.
package fir_pkg;

  localparam int unsigned FIR_WIDTH          = 10;
  localparam int unsigned DECIM_LOG2_DEFAULT = 2;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 2;

  typedef logic [FIR_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, 2**DEPTH_LOG2 entries of WIDTH bits.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   i_push, i_data  write request and data; accepted when not full, or when full with a pop
//   i_pop           read request; ignored when empty
//   o_data          head entry, 0 when empty
//   o_full, o_empty occupancy flags
//   o_fill          occupancy 0..2**DEPTH_LOG2
module sync_fifo #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [DEPTH_LOG2:0] o_fill
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_wr_en;
  logic                w_rd_en;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_fill  = r_wr_ptr - r_rd_ptr;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr_en = i_push & (~o_full | i_pop);
  assign w_rd_en = i_pop & ~o_empty;

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Decimating output stage of the FIR filter. Keeps one of every 2**DECIM_LOG2
// input samples and queues it in a show-ahead FIFO drained by valid/ready.
// A sample lost because the FIFO is full sets a sticky overflow flag.
// Build option: define DECIM_AVG_EN to push the boxcar average of each group
// instead of the last sample of the group.
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   in_data, in_valid    filtered sample stream (unsigned)
//   out_data, out_valid  FIFO head and not-empty
//   out_ready            consumer pops the head when out_valid & out_ready
//   fill                 FIFO occupancy
//   overflow             sticky drop flag; clear_overflow clears it synchronously
module fir_decimator
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH      = FIR_WIDTH,
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEFAULT,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] fill,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int unsigned D      = 1 << DECIM_LOG2;
  // Keep the counter at least one bit wide so D=1 still elaborates.
  localparam int unsigned PHASE_W = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(D - 1);

  logic [PHASE_W-1:0] r_phase;
  logic               r_overflow;
  logic               w_emit;
  logic [WIDTH-1:0]   w_push_data;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;

  assign w_emit = in_valid & (r_phase == PHASE_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (in_valid) begin
      r_phase <= w_emit ? '0 : r_phase + PHASE_W'(1);
    end
  end

`ifdef DECIM_AVG_EN
  localparam int unsigned ACC_W = WIDTH + DECIM_LOG2;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;

  // At most D samples are summed before the clear, so ACC_W never overflows.
  assign w_sum       = r_acc + ACC_W'(in_data);
  assign w_push_data = w_sum[ACC_W-1:DECIM_LOG2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (in_valid) begin
      r_acc <= w_emit ? '0 : w_sum;
    end
  end
`else
  assign w_push_data = in_data;
`endif

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  // Only a push into a full FIFO without a coincident pop loses data.
  assign w_drop    = w_emit & w_full & ~w_pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

  sync_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_emit),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (fill)
  );

endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;

  localparam int unsigned WIDTH      = 10;
  localparam int unsigned DEPTH_LOG2 = 2;

  logic                clock;
  logic                reset_n;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [DEPTH_LOG2:0] fill;
  logic                overflow;
  logic                clear_overflow;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_val;
  bit track_fill = 0;
  int max_fill = 0;

  fir_decimator #(
    .WIDTH      (WIDTH),
    .DECIM_LOG2 (2),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fill           (fill),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 30; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_out_valid", int'(out_valid), 0);
  endtask

  // Scoreboard monitor: every handshake pops and compares the next expected sample.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d required=none", out_data);
      end else begin
        exp_val = exp_q.pop_front();
        check("out_data", int'(out_data), exp_val);
      end
    end
    if (track_fill && int'(fill) > max_fill) max_fill = int'(fill);
  end

  initial begin
    reset_n        = 1'b0;
    in_valid       = 1'b1;
    in_data        = 10'd7;
    out_ready      = 1'b1;
    clear_overflow = 1'b0;

    // Reset with in_valid held high
    repeat (3) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_out_data", int'(out_data), 0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_fill", int'(fill), 0);

    // Pick mode, continuous input 1..12 -> 4, 8, 12
    track_fill = 1;
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0) exp_q.push_back(i);
      send(i);
      if (i == 3) check("no_push_before_4th", int'(out_valid), 0);
      if (i % 4 == 0) check("valid_1clk_after_push", int'(out_valid), 1);
    end
    wait_drain();
    track_fill = 0;
    check("max_fill", max_fill, 1);

    // Gapped input 10..17, one valid every three cycles -> 13, 17
    for (int i = 10; i <= 17; i++) begin
      if ((i - 9) % 4 == 0) exp_q.push_back(i);
      send(i);
      tick();
      tick();
    end
    wait_drain();

    // Back-pressure: five pushes into a depth-4 FIFO
    out_ready = 1'b0;
    for (int i = 21; i <= 40; i++) begin
      if ((i - 20) % 4 == 0 && i != 40) exp_q.push_back(i);
      send(i);
      if (i == 36) begin
        check("bp_fill_full", int'(fill), 4);
        check("bp_no_overflow_yet", int'(overflow), 0);
      end
    end
    check("bp_fill_after_drop", int'(fill), 4);
    check("bp_overflow_set", int'(overflow), 1);
    out_ready = 1'b1;
    wait_drain();
    check("bp_fill_empty", int'(fill), 0);
    check("bp_overflow_sticky", int'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("bp_overflow_cleared", int'(overflow), 0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 41; i <= 59; i++) begin
      if ((i - 40) % 4 == 0) exp_q.push_back(i);
      send(i);
    end
    check("full_fill", int'(fill), 4);
    exp_q.push_back(60);
    out_ready = 1'b1;
    send(60);
    out_ready = 1'b0;
    check("push_pop_fill", int'(fill), 4);
    check("push_pop_no_overflow", int'(overflow), 0);

    // Drop coincident with clear_overflow: set wins
    send(61);
    send(62);
    send(63);
    clear_overflow = 1'b1;
    send(64);
    clear_overflow = 1'b0;
    check("set_beats_clear", int'(overflow), 1);
    check("drop_fill", int'(fill), 4);
    out_ready = 1'b1;
    wait_drain();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("final_overflow_clear", int'(overflow), 0);

`ifdef DECIM_AVG_EN
    // Boxcar average mode
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(1);
    send(2);
    send(3);
    exp_q.push_back(2);
    send(5);
    send(1023);
    send(1023);
    send(1023);
    exp_q.push_back(1023);
    send(1023);
    wait_drain();
    // Reset mid-group discards the partial sum
    send(100);
    send(100);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(8);
    send(8);
    send(8);
    exp_q.push_back(8);
    send(8);
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
